bcd_score_display: RTL
======================

# bcd_score_display

Parametrised decimal score unit for the Tetris top level. It replaces the raw binary score and the per-nibble hex decoders with a BCD accumulator of `DIGITS` decimal digits, a high-score register, and N-digit seven-segment drive. It accepts binary point increments from `control` over a valid/ready handshake and saturates at all-nines.

## Interface
- `DIGITS`, default 4: number of decimal digits. Legal range 1..8.
- `ADD_W`, default 8: width of the binary increment `add_value`.

- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: asynchronous, active-high reset.
- `add_valid` in 1: increment request.
- `add_ready` out 1: unit is idle and able to accept.
- `add_value` in ADD_W: unsigned binary increment.
- `clear` in 1: zero the current score (new game). The high score is kept.
- `show_high` in 1: 1 shows `high_bcd` on `seg`; 0 shows `score_bcd`.
- `score_bcd` out 4*DIGITS: current score. Digit i is in bits [4i+3:4i].
- `high_bcd` out 4*DIGITS: highest committed score since reset.
- `new_high` out 1: one-cycle pulse when `high_bcd` is raised.
- `saturated` out 1: sticky flag; the score has clamped at all-nines.
- `seg` out 7*DIGITS: seven-segment drive, active-low, {g,f,e,d,c,b,a} per digit. Digit i is in bits [7i+6:7i].

## Operation
- The FSM has four states: IDLE, CONV, ADD, CMP.
- `add_ready` = (state==IDLE) & ~clear. It is 0 while `reset` is asserted.
- **IDLE**
  - Handshake at an edge where `add_valid & add_ready`: latch `add_value`, clear the BCD work register, go to CONV.
- **CONV** (ADD_W cycles): double-dabble conversion.
  - Each cycle, every BCD nibble ≥5 gets +3, then the register shifts left 1 with the next `add_value` bit, MSB first.
  - Any 1 shifted out of the top nibble sets an internal overflow flag.
- **ADD** (DIGITS cycles): digit-serial BCD add of the work register to a copy of the score, least significant digit first.
  - Per digit: s = a + b + carry. If s > 9, the digit is s−10 and carry=1. Otherwise the digit is s and carry=0.
- **CMP** (1 cycle): commit.
  - If the overflow flag is set or the final carry is 1: `score_bcd` = all 9s and `saturated` = 1.
  - Otherwise `score_bcd` = the sum.
  - If the committed value is strictly greater than `high_bcd`: `high_bcd` takes the committed value and `new_high` pulses for this one cycle.
  - Return to IDLE.
- **`clear`**
  - Honoured in any state. At the next edge: `score_bcd` = 0, `saturated` = 0, FSM to IDLE, any in-flight add discarded.
  - `high_bcd` is untouched.
  - Clear beats a simultaneous `add_valid`: no accept.
- **Saturated score:** further adds are still accepted and keep all-9s.
- **`seg`**
  - Combinational from the selected BCD register.
  - Digits 0–9 use the standard patterns ("0"=7'h40, "3"=7'h30, "7"=7'h78).
  - Nibbles A–F never occur. If they do, drive blank (7'h7F).

## Timing
- Reset values:
  - FSM = IDLE.
  - `score_bcd` = 0, `high_bcd` = 0, `saturated` = 0, `new_high` = 0.
  - `add_ready` = 0 during reset, 1 in the first cycle after release (with `clear` low).
  - `seg` shows "0" on digit 0.
- Label the accept edge as edge 0.
  - CONV occupies edges 1..ADD_W.
  - ADD occupies edges ADD_W+1..ADD_W+DIGITS.
  - The commit edge is ADD_W+DIGITS+1.
- Outputs change at the commit edge: `score_bcd`, `high_bcd`, `saturated`, and the `new_high` pulse (high for the cycle after that edge).
- `add_ready` rises after the commit edge. The earliest next accept is edge ADD_W+DIGITS+2.
- Defaults (ADD_W=8, DIGITS=4) give a commit 13 edges after accept and a throughput of one add per 14 cycles.
- `clear` takes effect at the next edge. `add_ready` is high the cycle after, if `clear` has been deasserted.
- `reset` mid-operation returns everything to reset values immediately, including `high_bcd`.

## Configuration
- `SCORE_LZB_EN` (leading-zero blanking).
- **Defined:** digits above the most significant non-zero digit drive 7'h7F. Digit 0 is always shown, so a score of 0 displays "0".
- **Undefined:** all DIGITS digits are always shown, with leading zeros as "0" (7'h40).

## Test plan
- Default parameters, reset, add 40 then add 123 → `score_bcd`=0x0163; each commit exactly 13 edges after its accept; `seg[6:0]`=7'h30.
- Add 255 forty times → `score_bcd`=0x9999, `saturated`=1. Then `clear` → score 0x0000, `saturated`=0, `high_bcd`=0x9999.
- Add 50, clear, add 30 → `high_bcd`=0x0050, `score_bcd`=0x0030; `new_high` pulses once (first commit only); `show_high`=1 displays 0050.
- Assert `clear` during ADD of an add of 99 → no commit, `score_bcd`=0; `add_ready`=1 the cycle after `clear` drops. `clear` and `add_valid` together in IDLE → `add_ready`=0, no accept.
- DIGITS=2: add 255 → conversion overflow → `score_bcd`=0x99, `saturated`=1.
- Score 0x0007: with `SCORE_LZB_EN`, digits 3..1 = 7'h7F; without, 7'h40; digit 0 = 7'h78 in both builds.

Source files
------------

// File: rtl/bcd_score_display.sv
// Decimal score unit: binary increments converted by double-dabble, digit-serial BCD add,
// saturating at all-nines, high-score tracking and 7-seg drive. Optional macro: SCORE_LZB_EN.
module bcd_score_display #(
    parameter int DIGITS = 4,
    parameter int ADD_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  add_valid,
    output logic                  add_ready,
    input  logic [ADD_W-1:0]      add_value,
    input  logic                  clear,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  new_high,
    output logic                  saturated,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW = 4 * DIGITS;
    localparam int MX = (ADD_W > DIGITS) ? ADD_W : DIGITS;
    localparam int CW = $clog2(MX) + 1;

    typedef enum logic [1:0] {IDLE, CONV, ADD, CMP} state_t;

    state_t          state_q, state_d;
    logic [ADD_W-1:0] val_q, val_d;
    logic [BW-1:0]   work_q, work_d;
    logic [BW-1:0]   acc_q, acc_d;
    logic [BW-1:0]   score_q, score_d;
    logic [BW-1:0]   high_q, high_d;
    logic            ovf_q, ovf_d;
    logic            carry_q, carry_d;
    logic            sat_q, sat_d;
    logic            nh_q, nh_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [BW-1:0]   adj;
    logic [4:0]      sum;
    logic [3:0]      digit;
    logic [BW-1:0]   commit;

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        work_d  = work_q;
        acc_d   = acc_q;
        score_d = score_q;
        high_d  = high_q;
        ovf_d   = ovf_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        nh_d    = 1'b0;
        cnt_d   = cnt_q;

        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end

        sum   = {1'b0, acc_q[3:0]} + {1'b0, work_q[3:0]} + {4'b0, carry_q};
        digit = (sum > 5'd9) ? 4'(sum - 5'd10) : sum[3:0];

        commit = (ovf_q | carry_q) ? {DIGITS{4'h9}} : acc_q;

        if (clear) begin
            state_d = IDLE;
            score_d = '0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (add_valid) begin
                        val_d   = add_value;
                        work_d  = '0;
                        acc_d   = score_q;
                        ovf_d   = 1'b0;
                        carry_d = 1'b0;
                        cnt_d   = '0;
                        state_d = CONV;
                    end
                end
                CONV: begin
                    work_d = {adj[BW-2:0], val_q[ADD_W-1]};
                    ovf_d  = ovf_q | adj[BW-1];
                    val_d  = val_q << 1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(ADD_W - 1)) begin
                        cnt_d   = '0;
                        state_d = ADD;
                    end
                end
                ADD: begin
                    // Sum digits rotate in at the top; after DIGITS steps acc_q is in order.
                    acc_d   = (acc_q >> 4) | (BW'(digit) << (BW - 4));
                    work_d  = work_q >> 4;
                    carry_d = (sum > 5'd9);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(DIGITS - 1)) begin
                        cnt_d   = '0;
                        state_d = CMP;
                    end
                end
                CMP: begin
                    score_d = commit;
                    if (ovf_q | carry_q)
                        sat_d = 1'b1;
                    if (commit > high_q) begin
                        high_d = commit;
                        nh_d   = 1'b1;
                    end
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            work_q  <= '0;
            acc_q   <= '0;
            score_q <= '0;
            high_q  <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            nh_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            score_q <= score_d;
            high_q  <= high_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            sat_q   <= sat_d;
            nh_q    <= nh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign add_ready = (state_q == IDLE) & ~clear & ~reset;
    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign new_high  = nh_q;
    assign saturated = sat_q;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0: p = 7'h40;
            4'd1: p = 7'h79;
            4'd2: p = 7'h24;
            4'd3: p = 7'h30;
            4'd4: p = 7'h19;
            4'd5: p = 7'h12;
            4'd6: p = 7'h02;
            4'd7: p = 7'h78;
            4'd8: p = 7'h00;
            4'd9: p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    logic [BW-1:0] sel;
`ifdef SCORE_LZB_EN
    logic lead;
`endif

    always_comb begin
        sel = show_high ? high_q : score_q;
        seg = '0;
        for (int i = 0; i < DIGITS; i++)
            seg[7*i +: 7] = seg7(sel[4*i +: 4]);
`ifdef SCORE_LZB_EN
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (sel[4*i +: 4] != 4'd0)
                lead = 1'b0;
            if (lead)
                seg[7*i +: 7] = 7'h7F;
        end
`endif
    end

endmodule
